// File: rtl/fp16_pkg.sv
// Shared types and field constants for the fp16 multiplier arbiter.
// Stage records carry a fixed-width id wide enough for up to eight requesters.
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam int SIGN_BIT = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 10;
  localparam int MANT_HI  = 9;
  localparam int MANT_LO  = 0;
  localparam int BIAS     = 15;
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    fp16_t               a;
    fp16_t               b;
  } mul_stage_t;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    fp16_t               prod;
  } resp_stage_t;

endpackage

// File: rtl/floatMut.sv
// Existing combinational fp16 multiplier: XOR sign, biased exponent add, truncated mantissa.
// Negative result exponent flushes to +0; no NaN/Inf/denormal/rounding handling.
module floatMut (
  input  logic [15:0] floatA,
  input  logic [15:0] floatB,
  output logic [15:0] product
);

  logic              sign_s;
  logic [10:0]       ma_s;
  logic [10:0]       mb_s;
  logic [21:0]       mp_s;
  logic signed [6:0] exp_s;
  logic [9:0]        mant_s;

  // Mantissa product, normalisation by at most one place, exponent rebias.
  always_comb begin
    sign_s = floatA[15] ^ floatB[15];
    ma_s   = {1'b1, floatA[9:0]};
    mb_s   = {1'b1, floatB[9:0]};
    mp_s   = 22'(ma_s) * 22'(mb_s);
    exp_s  = $signed({2'b00, floatA[14:10]}) + $signed({2'b00, floatB[14:10]})
             - 7'sd15 + (mp_s[21] ? 7'sd1 : 7'sd0);
    mant_s = 10'(mp_s >> (mp_s[21] ? 5'd11 : 5'd10));
    if (exp_s < 7'sd0) begin
      product = 16'h0000;
    end else begin
      product = {sign_s, exp_s[4:0], mant_s};
    end
  end

endmodule

// File: rtl/fp16_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
// Produces a one-hot grant and its encoded index.
module fp16_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o
);

  logic            found_s;
  logic [ID_W-1:0] idx_s;
  int              idx_int_s;

  // Scan offsets 1..NUM_REQ from the pointer so the last winner has lowest priority.
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found_s    = 1'b0;
    idx_int_s  = 0;
    idx_s      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx_int_s = (int'(ptr_i) + off) % NUM_REQ;
      idx_s     = ID_W'(idx_int_s);
      if (!found_s && req_i[idx_s]) begin
        found_s        = 1'b1;
        grant_o[idx_s] = 1'b1;
        grant_id_o     = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one floatMut among NUM_REQ requesters: round-robin grant, two-stage pipeline,
// single tagged response channel with backpressure that freezes the whole pipe.
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [15:0]           resp_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  mul_stage_t        s1_q, s1_d;
  resp_stage_t       s2_q, s2_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]   grant_id_s;
  logic              advance_s;
  logic              hs_s;
  fp16_t             prod_s;

  fp16_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant_s),
    .grant_id_o (grant_id_s)
  );

  floatMut u_mul (
    .floatA  (s1_q.a),
    .floatB  (s1_q.b),
    .product (prod_s)
  );

  // Grant gating, pipeline advance and counter next-state.
  always_comb begin
    advance_s  = !(s2_q.valid && !resp_ready);
    req_ready  = '0;
    s1_d       = s1_q;
    s2_d       = s2_q;
    rr_ptr_d   = rr_ptr_q;
    op_count_d = op_count_q;
    if (rst || !advance_s) begin
      req_ready = '0;
    end else begin
      req_ready = grant_s;
    end
    hs_s = |(req_valid & req_ready);
    if (advance_s) begin
      s1_d.valid = hs_s;
      s1_d.id    = MAX_ID_W'(grant_id_s);
      s1_d.a     = req_a[{grant_id_s, 4'b0000} +: 16];
      s1_d.b     = req_b[{grant_id_s, 4'b0000} +: 16];
      s2_d.valid = s1_q.valid;
      s2_d.id    = s1_q.id;
      s2_d.prod  = prod_s;
    end else begin
      s1_d = s1_q;
      s2_d = s2_q;
    end
    if (hs_s) begin
      rr_ptr_d = grant_id_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (s2_q.valid && resp_ready) begin
      op_count_d = op_count_q + CNT_W'(1);
    end else begin
      op_count_d = op_count_q;
    end
  end

  // Pipeline, pointer and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      op_count_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      rr_ptr_q   <= rr_ptr_d;
      op_count_q <= op_count_d;
    end
  end

  assign resp_valid = s2_q.valid;
  assign resp_id    = ID_W'(s2_q.id);
  assign resp_data  = s2_q.prod;
  assign busy       = s1_q.valid | s2_q.valid;
  assign op_count   = op_count_q;

endmodule
